// File: rtl/mem_arbiter.sv
// Two-client cache-line memory arbiter (icache read / dcache read or write) with a single memory port.
// Optional ARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests instead of fixed dcache priority.
module mem_arbiter #(
    parameter int ADDRESS_WIDTH    = 32,
    parameter int CACHE_LINE_WIDTH = 128
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        icache_req_in,
    input  logic [ADDRESS_WIDTH-1:0]    icache_addr_in,
    input  logic                        dcache_req_in,
    input  logic                        dcache_write_in,
    input  logic [ADDRESS_WIDTH-1:0]    dcache_addr_in,
    input  logic [CACHE_LINE_WIDTH-1:0] dcache_data_in,
    output logic                        icache_grant_out,
    output logic                        dcache_grant_out,
    output logic                        icache_fill_out,
    output logic                        dcache_fill_out,
    output logic [CACHE_LINE_WIDTH-1:0] fill_data_out,
    output logic [ADDRESS_WIDTH-1:0]    fill_addr_out,
    output logic                        mem_req_out,
    output logic                        mem_write_out,
    output logic [ADDRESS_WIDTH-1:0]    mem_addr_out,
    output logic [CACHE_LINE_WIDTH-1:0] mem_data_out,
    input  logic                        mem_ready_in,
    input  logic [CACHE_LINE_WIDTH-1:0] mem_data_in,
    output logic [1:0]                  debug_state
);

    // Handshake: a requester holds req until it sees its grant fall or its fill pulse;
    // requests are only sampled in IDLE, and mem_ready_in is only honoured in WAIT.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]                  state;
    logic                        owner_dcache;
    logic                        lat_write;
    logic [ADDRESS_WIDTH-1:0]    lat_addr;
    logic [CACHE_LINE_WIDTH-1:0] lat_data;
    logic [CACHE_LINE_WIDTH-1:0] fill_data;
    logic [ADDRESS_WIDTH-1:0]    fill_addr;
    logic                        pick_dcache;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_dcache;  // 0 after reset means "icache granted last"

    assign pick_dcache = dcache_req_in && (!icache_req_in || !last_dcache);

    always_ff @(posedge clk) begin
        if (reset) begin
            last_dcache <= 1'b0;
        end else if (state == IDLE && (icache_req_in || dcache_req_in)) begin
            last_dcache <= pick_dcache;
        end
    end
`else
    assign pick_dcache = dcache_req_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner_dcache <= 1'b0;
            lat_write    <= 1'b0;
            lat_addr     <= '0;
            lat_data     <= '0;
            fill_data    <= '0;
            fill_addr    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (icache_req_in || dcache_req_in) begin
                        owner_dcache <= pick_dcache;
                        lat_write    <= pick_dcache && dcache_write_in;
                        lat_addr     <= pick_dcache ? dcache_addr_in : icache_addr_in;
                        lat_data     <= pick_dcache ? dcache_data_in : '0;
                        state        <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mem_ready_in) begin
                        fill_data <= mem_data_in;
                        fill_addr <= lat_addr;
                        state     <= RESP;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // All outputs decode registered state only, so no input reaches an output combinationally.
    assign icache_grant_out = (state != IDLE) && !owner_dcache;
    assign dcache_grant_out = (state != IDLE) && owner_dcache;
    assign icache_fill_out  = (state == RESP) && !owner_dcache;
    assign dcache_fill_out  = (state == RESP) && owner_dcache && !lat_write;
    assign fill_data_out    = fill_data;
    assign fill_addr_out    = fill_addr;
    assign mem_req_out      = (state == ISSUE);
    assign mem_write_out    = (state == ISSUE) && lat_write;
    assign mem_addr_out     = lat_addr;
    assign mem_data_out     = lat_data;
    assign debug_state      = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized transactions
// against a transaction-level model of arbitration and fill behaviour.
module tb_mem_arbiter;
    localparam int AW = 32;
    localparam int LW = 128;

    logic          clk;
    logic          reset;
    logic          icache_req_in;
    logic [AW-1:0] icache_addr_in;
    logic          dcache_req_in;
    logic          dcache_write_in;
    logic [AW-1:0] dcache_addr_in;
    logic [LW-1:0] dcache_data_in;
    logic          icache_grant_out;
    logic          dcache_grant_out;
    logic          icache_fill_out;
    logic          dcache_fill_out;
    logic [LW-1:0] fill_data_out;
    logic [AW-1:0] fill_addr_out;
    logic          mem_req_out;
    logic          mem_write_out;
    logic [AW-1:0] mem_addr_out;
    logic [LW-1:0] mem_data_out;
    logic          mem_ready_in;
    logic [LW-1:0] mem_data_in;
    logic [1:0]    debug_state;

    mem_arbiter #(.ADDRESS_WIDTH(AW), .CACHE_LINE_WIDTH(LW)) dut (
        .clk              (clk),
        .reset            (reset),
        .icache_req_in    (icache_req_in),
        .icache_addr_in   (icache_addr_in),
        .dcache_req_in    (dcache_req_in),
        .dcache_write_in  (dcache_write_in),
        .dcache_addr_in   (dcache_addr_in),
        .dcache_data_in   (dcache_data_in),
        .icache_grant_out (icache_grant_out),
        .dcache_grant_out (dcache_grant_out),
        .icache_fill_out  (icache_fill_out),
        .dcache_fill_out  (dcache_fill_out),
        .fill_data_out    (fill_data_out),
        .fill_addr_out    (fill_addr_out),
        .mem_req_out      (mem_req_out),
        .mem_write_out    (mem_write_out),
        .mem_addr_out     (mem_addr_out),
        .mem_data_out     (mem_data_out),
        .mem_ready_in     (mem_ready_in),
        .mem_data_in      (mem_data_in),
        .debug_state      (debug_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            pass_cnt  = 0;
    int            total_cnt = 0;
    logic [LW-1:0] exp_q[$];
    bit            model_last_dcache;
    logic [LW-1:0] model_fill_data;

    // reference model: who wins when the arbiter looks at these requests
    function automatic bit model_pick_dcache(bit ir, bit dr);
`ifdef ARB_ROUND_ROBIN_EN
        if (ir && dr) return !model_last_dcache;
`endif
        return dr;
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk_a(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_w(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // driver: called in an IDLE cycle; runs one full transaction and checks every phase
    task automatic do_txn(input bit ir, input bit dr, input bit dw,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [LW-1:0] dd, input int lat, input bit early,
                          input logic [LW-1:0] rdata, input bit hold);
        bit            win_d;
        bit            wr;
        logic [AW-1:0] ea;
        logic [LW-1:0] got;
        icache_req_in   = ir;
        icache_addr_in  = ia;
        dcache_req_in   = dr;
        dcache_write_in = dw;
        dcache_addr_in  = da;
        dcache_data_in  = dd;
        win_d = model_pick_dcache(ir, dr);
        wr    = win_d && dw;
        ea    = win_d ? da : ia;
        step();
        chk_b("issue_icache_grant", icache_grant_out, !win_d);
        chk_b("issue_dcache_grant", dcache_grant_out, win_d);
        chk_b("issue_mem_req", mem_req_out, 1'b1);
        chk_b("issue_mem_write", mem_write_out, wr);
        chk_a("issue_mem_addr", mem_addr_out, ea);
        if (wr) chk_w("issue_mem_data", mem_data_out, dd);
        model_last_dcache = win_d;
        // requester inputs wander after the latch; ready in ISSUE must be ignored
        icache_addr_in  = $urandom;
        dcache_addr_in  = $urandom;
        dcache_data_in  = rand_line();
        dcache_write_in = 1'($urandom_range(0, 1));
        mem_ready_in    = early;
        mem_data_in     = rand_line();
        step();
        mem_ready_in = 1'b0;
        for (int i = 0; i < lat; i++) begin
            chk_b("wait_icache_grant", icache_grant_out, !win_d);
            chk_b("wait_dcache_grant", dcache_grant_out, win_d);
            chk_b("wait_mem_req", mem_req_out, 1'b0);
            chk_b("wait_no_fill", icache_fill_out | dcache_fill_out, 1'b0);
            step();
        end
        mem_ready_in = 1'b1;
        mem_data_in  = rdata;
        exp_q.push_back(rdata);
        step();
        mem_ready_in = 1'b0;
        mem_data_in  = rand_line();
        if (!hold) begin
            icache_req_in = 1'b0;
            dcache_req_in = 1'b0;
        end
        got = exp_q.pop_front();
        model_fill_data = got;
        chk_b("resp_icache_fill", icache_fill_out, !win_d);
        chk_b("resp_dcache_fill", dcache_fill_out, win_d && !wr);
        chk_b("resp_icache_grant", icache_grant_out, !win_d);
        chk_b("resp_dcache_grant", dcache_grant_out, win_d);
        chk_b("resp_mem_req", mem_req_out, 1'b0);
        if (!wr) begin
            chk_w("resp_fill_data", fill_data_out, got);
            chk_a("resp_fill_addr", fill_addr_out, ea);
        end
        step();
        chk_b("idle_grants", icache_grant_out | dcache_grant_out, 1'b0);
        chk_b("idle_fills", icache_fill_out | dcache_fill_out, 1'b0);
        chk_b("idle_mem_req", mem_req_out, 1'b0);
        chk_w("idle_fill_data_hold", fill_data_out, model_fill_data);
    endtask

    initial begin
        reset           = 1'b1;
        icache_req_in   = 1'b0;
        icache_addr_in  = '0;
        dcache_req_in   = 1'b0;
        dcache_write_in = 1'b0;
        dcache_addr_in  = '0;
        dcache_data_in  = '0;
        mem_ready_in    = 1'b0;
        mem_data_in     = '0;
        model_last_dcache = 1'b0;
        model_fill_data   = '0;
        step();
        step();
        reset = 1'b0;
        chk_b("reset_grants", icache_grant_out | dcache_grant_out, 1'b0);
        chk_b("reset_fills", icache_fill_out | dcache_fill_out, 1'b0);
        chk_b("reset_mem_req", mem_req_out, 1'b0);
        chk_b("reset_mem_write", mem_write_out, 1'b0);
        chk_a("reset_mem_addr", mem_addr_out, '0);
        chk_w("reset_fill_data", fill_data_out, '0);
        chk_a("reset_fill_addr", fill_addr_out, '0);
        chk_b("reset_state_idle", debug_state == 2'd0, 1'b1);

        // ready pulse while idle is ignored
        mem_ready_in = 1'b1;
        mem_data_in  = rand_line();
        step();
        mem_ready_in = 1'b0;
        chk_b("idle_ready_grants", icache_grant_out | dcache_grant_out, 1'b0);
        chk_b("idle_ready_mem_req", mem_req_out, 1'b0);
        chk_b("idle_ready_fill", icache_fill_out | dcache_fill_out, 1'b0);
        step();

        // icache read, ready three cycles after mem_req
        do_txn(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, '0, 2, 1'b0, {16{8'hA5}}, 1'b0);
        chk_a("icache_fill_addr_hold", fill_addr_out, 32'h100);
        // dcache write, with a ready pulse during ISSUE
        do_txn(1'b0, 1'b1, 1'b1, 32'h0, 32'h200, 128'h1234, 1, 1'b1, rand_line(), 1'b0);
        // dcache read
        do_txn(1'b0, 1'b1, 1'b0, 32'h0, 32'h240, '0, 0, 1'b0, rand_line(), 1'b0);

        // both requesting continuously
        for (int k = 0; k < 4; k++)
            do_txn(1'b1, 1'b1, 1'b0, 32'h400 + 32'(k), 32'h800 + 32'(k), '0, 1, 1'b0, rand_line(), k < 3);

        // reset during WAIT abandons the transaction
        icache_req_in  = 1'b1;
        icache_addr_in = 32'h300;
        step();
        icache_req_in = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        model_last_dcache = 1'b0;
        model_fill_data   = '0;
        mem_ready_in = 1'b1;
        mem_data_in  = rand_line();
        chk_b("rst_wait_grants", icache_grant_out | dcache_grant_out, 1'b0);
        chk_b("rst_wait_mem_req", mem_req_out, 1'b0);
        step();
        mem_ready_in = 1'b0;
        chk_b("rst_late_ready_fill", icache_fill_out | dcache_fill_out, 1'b0);
        chk_b("rst_late_ready_grants", icache_grant_out | dcache_grant_out, 1'b0);
        chk_b("rst_late_ready_mem_req", mem_req_out, 1'b0);
        chk_w("rst_fill_data_cleared", fill_data_out, '0);
        do_txn(1'b1, 1'b0, 1'b0, 32'h140, 32'h0, '0, 1, 1'b0, rand_line(), 1'b0);

        // randomized transactions
        for (int k = 0; k < 25; k++) begin
            bit ir;
            bit dr;
            ir = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            if (!ir && !dr) dr = 1'b1;
            do_txn(ir, dr, 1'($urandom_range(0, 1)), $urandom, $urandom, rand_line(),
                   int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)), rand_line(), 1'b0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
